// File: rtl/hypercorex_pkg.sv
// hypercorex_pkg: shared types and constants for the hypercorex register-file datapath.
package hypercorex_pkg;

  localparam int BusWidthDefault = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/reg_file_loader.sv
// reg_file_loader: assembles bus beats into wide vectors and writes them to consecutive registers.
// Optional REG_FILE_LOADER_STATUS_EN adds loaded_cnt_o, a saturating count of issued writes.
module reg_file_loader
  import hypercorex_pkg::*;
#(
  parameter int DataWidth    = 512,
  parameter int BusWidth     = BusWidthDefault,
  parameter int NumRegs      = 4,
  parameter int NumRegsWidth = $clog2(NumRegs),
  parameter int NumBeats     = DataWidth / BusWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NumRegsWidth-1:0] start_addr_i,
  input  logic [NumRegsWidth:0]   num_vecs_i,
  input  logic [BusWidth-1:0]     bus_data_i,
  input  logic                    bus_valid_i,
  output logic                    bus_ready_o,
  output logic [NumRegsWidth-1:0] wr_addr_o,
  output logic [DataWidth-1:0]    wr_data_o,
  output logic                    wr_en_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef REG_FILE_LOADER_STATUS_EN
  ,
  output logic [31:0]             loaded_cnt_o
`endif
);

  localparam int BeatWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(NumBeats - 1);
  localparam logic [NumRegsWidth-1:0] LastAddr = NumRegsWidth'(NumRegs - 1);

  loader_state_t           state_q;
  logic [BeatWidth-1:0]    beat_q;
  logic [NumRegsWidth:0]   vec_q;
  logic [NumRegsWidth-1:0] addr_q;
  logic [DataWidth-1:0]    buf_q;
  logic [DataWidth-1:0]    buf_nxt;

  always_comb begin
    buf_nxt = buf_q;
    buf_nxt[beat_q*BusWidth +: BusWidth] = bus_data_i;
  end

  assign bus_ready_o = state_q == FILL;
  assign wr_en_o     = state_q == WRITE;
  assign done_o      = state_q == DONE;
  assign busy_o      = state_q != IDLE;

  // The write port registers are loaded on the last beat so they hold between writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      vec_q     <= '0;
      addr_q    <= '0;
      buf_q     <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          addr_q  <= start_addr_i;
          vec_q   <= num_vecs_i;
          beat_q  <= '0;
          state_q <= (num_vecs_i == '0) ? DONE : FILL;
        end
        FILL: if (bus_valid_i) begin
          buf_q <= buf_nxt;
          if (beat_q == LastBeat) begin
            beat_q    <= '0;
            wr_data_o <= buf_nxt;
            wr_addr_o <= addr_q;
            state_q   <= WRITE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        WRITE: begin
          addr_q  <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
          vec_q   <= vec_q - 1'b1;
          state_q <= (vec_q == 1) ? DONE : FILL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REG_FILE_LOADER_STATUS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) loaded_cnt_o <= '0;
    else if (wr_en_o && loaded_cnt_o != '1) loaded_cnt_o <= loaded_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_reg_file_loader.sv
// tb_reg_file_loader: randomized self-checking bench for reg_file_loader (64-bit vectors, 32-bit beats, 4 regs).
module tb_reg_file_loader;

  localparam int DW = 64, BW = 32, NR = 4, NRW = 2;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           start_i = 1'b0;
  logic [NRW-1:0] start_addr_i = '0;
  logic [NRW:0]   num_vecs_i = '0;
  logic [BW-1:0]  bus_data_i = '0;
  logic           bus_valid_i = 1'b0;
  logic           bus_ready_o, wr_en_o, busy_o, done_o;
  logic [NRW-1:0] wr_addr_o;
  logic [DW-1:0]  wr_data_o;
`ifdef REG_FILE_LOADER_STATUS_EN
  logic [31:0]    loaded_cnt_o;
`endif

  reg_file_loader #(.DataWidth(DW), .BusWidth(BW), .NumRegs(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .num_vecs_i(num_vecs_i), .bus_data_i(bus_data_i), .bus_valid_i(bus_valid_i),
    .bus_ready_o(bus_ready_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o)
`ifdef REG_FILE_LOADER_STATUS_EN
    , .loaded_cnt_o(loaded_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int passed = 0, total = 0, cyc = 0;
  int busy_cnt, busy_first, busy_last, done_cyc, done_cnt;
  logic [NRW-1:0] wa_q[$], exp_a[$];
  logic [DW-1:0]  wd_q[$], exp_d[$];
  logic [BW-1:0]  fix_q[$];
  int             wc_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) if (!rst_i) begin
    if (wr_en_o) begin
      wa_q.push_back(wr_addr_o);
      wd_q.push_back(wr_data_o);
      wc_q.push_back(cyc);
    end
    if (busy_o) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
    if (done_o) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_log;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); exp_a.delete(); exp_d.delete();
    busy_cnt = 0; busy_first = -1; busy_last = -1; done_cyc = -1; done_cnt = 0;
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input int stall, input bit poke);
    bit ok = 0;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == stall / 2) start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
    end
    bus_valid_i = 1'b1;
    bus_data_i  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = bus_ready_o;
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk_i); #1 bus_valid_i = 1'b0;
    bus_data_i = $urandom;
  endtask

  // Expected writes: vector v goes to (a+v) mod NR and is {beat 2v+1, beat 2v}.
  task automatic run_load(input string tag, input logic [NRW-1:0] a, input int n,
                          input int stall, input bit rnd, input bit poke);
    logic [BW-1:0] beats[$];
    clear_log();
    @(posedge clk_i); #1 start_i = 1'b1; start_addr_i = a; num_vecs_i = 3'(n);
    @(posedge clk_i); #1 start_i = 1'b0; start_addr_i = $urandom; num_vecs_i = 3'($urandom_range(4, 1));
    for (int i = 0; i < 2 * n; i++) beats.push_back(fix_q.size() > i ? fix_q[i] : $urandom);
    fix_q.delete();
    for (int v = 0; v < n; v++) begin
      exp_a.push_back(NRW'((int'(a) + v) % NR));
      exp_d.push_back({beats[2*v+1], beats[2*v]});
    end
    for (int i = 0; i < 2 * n; i++)
      send_beat(beats[i], rnd ? int'($urandom_range(stall, 0)) : stall, poke && i == 1);
    for (int i = 0; i < 20 && done_cnt == 0; i++) @(negedge clk_i);
    chk({tag, " done_count"}, 64'(done_cnt), 1);
    chk({tag, " write_count"}, 64'(wa_q.size()), 64'(n));
    for (int v = 0; v < n && v < wa_q.size(); v++) begin
      chk($sformatf("%s addr%0d", tag, v), 64'(wa_q[v]), 64'(exp_a[v]));
      chk($sformatf("%s data%0d", tag, v), wd_q[v], exp_d[v]);
    end
    chk({tag, " busy_contiguous"}, 64'(busy_last - busy_first + 1), 64'(busy_cnt));
    chk({tag, " done_last_busy"}, 64'(done_cyc), 64'(busy_last));
    if (n > 0 && wc_q.size() == n) chk({tag, " done_after_write"}, 64'(done_cyc), 64'(wc_q[n-1] + 1));
    if (n == 0) chk({tag, " busy_cycles"}, 64'(busy_cnt), 1);
    @(negedge clk_i);
    chk({tag, " idle_after"}, 64'(busy_o), 0);
    if (n > 0) chk({tag, " data_hold"}, wr_data_o, exp_d[n-1]);
  endtask

  initial begin
    clear_log();
    #12;
    chk("rst busy", 64'(busy_o), 0);
    chk("rst ready", 64'(bus_ready_o), 0);
    chk("rst wr_en", 64'(wr_en_o), 0);
    chk("rst done", 64'(done_o), 0);
    chk("rst addr", 64'(wr_addr_o), 0);
    chk("rst data", wr_data_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    run_load("r041", 2'd3, 3, 0, 1'b0, 1'b0);
`ifdef REG_FILE_LOADER_STATUS_EN
    chk("r045 loaded_cnt", 64'(loaded_cnt_o), 3);
`endif

    fix_q.push_back(32'hAAAA0001);
    fix_q.push_back(32'hBBBB0002);
    run_load("r040", 2'd1, 1, 0, 1'b0, 1'b0);
    if (wd_q.size() > 0) chk("r040 literal", wd_q[0], 64'hBBBB0002AAAA0001);

    run_load("r042", 2'd2, 0, 0, 1'b0, 1'b0);
    run_load("r043", 2'd0, 2, 5, 1'b0, 1'b1);

    clear_log();
    @(posedge clk_i); #1 start_i = 1'b1; start_addr_i = 2'd0; num_vecs_i = 3'd1;
    @(posedge clk_i); #1 start_i = 1'b0;
    send_beat(32'hDEAD0001, 0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("r044 rst busy", 64'(busy_o), 0);
    chk("r044 rst ready", 64'(bus_ready_o), 0);
    chk("r044 rst data", wr_data_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0; bus_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("r044 refused", 64'(bus_ready_o), 0);
    end
    bus_valid_i = 1'b0;
    chk("r044 no_write", 64'(wa_q.size()), 0);
    run_load("r044", 2'd2, 1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++)
      run_load($sformatf("rnd%0d", k), NRW'($urandom), int'($urandom_range(4, 0)), 3, 1'b1, k[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file_loader.md
REG_FILE_LOADER -- requirements
Module: reg_file_loader

Interface
REQ-001 SHALL have parameter DataWidth, default 512: register/vector width in bits.
REQ-002 SHALL have parameter BusWidth, default 32: input stream beat width; DataWidth SHALL be an integer multiple of BusWidth.
REQ-003 SHALL have parameter NumRegs, default 4: number of destination registers.
REQ-004 SHALL have derived parameters NumRegsWidth = $clog2(NumRegs) and NumBeats = DataWidth/BusWidth.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start_i, input, 1: single-cycle load request.
REQ-008 SHALL have port start_addr_i, input, NumRegsWidth: first destination register.
REQ-009 SHALL have port num_vecs_i, input, NumRegsWidth+1: vectors to load (0..NumRegs).
REQ-010 SHALL have port bus_data_i, input, BusWidth: stream beat.
REQ-011 SHALL have port bus_valid_i, input, 1: beat valid.
REQ-012 SHALL have port bus_ready_o, output, 1: beat accepted when valid and ready are both high.
REQ-013 SHALL have port wr_addr_o, output, NumRegsWidth: register-file write address.
REQ-014 SHALL have port wr_data_o, output, DataWidth: register-file write data.
REQ-015 SHALL have port wr_en_o, output, 1: register-file write enable.
REQ-016 SHALL have port busy_o, output, 1: a load is in progress.
REQ-017 SHALL have port done_o, output, 1: single-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-019 In IDLE, start_i high SHALL latch start_addr_i and num_vecs_i and go to FILL, or go to DONE if num_vecs_i is 0.
REQ-020 start_i SHALL be ignored in every state other than IDLE.
REQ-021 bus_ready_o SHALL be high only in FILL.
REQ-022 In FILL, beat k of a vector (k = 0..NumBeats-1) SHALL be stored in assembly buffer bits [k*BusWidth +: BusWidth], with beat 0 occupying the LSBs.
REQ-023 The beat counter SHALL advance only on a handshake; bus_valid_i low SHALL stall without losing state.
REQ-024 A handshake on beat NumBeats-1 SHALL move the FSM to WRITE on the next edge and reset the beat counter to 0.
REQ-025 In WRITE, wr_en_o SHALL be high for exactly one cycle, with wr_addr_o at the current address and wr_data_o at the full buffer.
REQ-026 The write SHALL occur in the cycle immediately after the last beat is accepted (latency 1).
REQ-027 After WRITE, the address SHALL increment modulo NumRegs (NumRegs-1 wraps to 0) and the remaining-vector count SHALL decrement.
REQ-028 After WRITE, the FSM SHALL go to FILL if the remaining count is nonzero, else to DONE.
REQ-029 DONE SHALL assert done_o for one cycle and then return to IDLE.
REQ-030 busy_o SHALL be high in FILL, WRITE and DONE.
REQ-031 wr_en_o SHALL be low outside WRITE; wr_addr_o and wr_data_o SHALL hold their last values.

Reset
REQ-032 rst_i high SHALL asynchronously force IDLE and clear the beat counter, vector count, address and buffer.
REQ-033 During reset, all outputs SHALL be 0.
REQ-034 Reset mid-load SHALL abandon the partial vector without issuing a write; subsequent beats SHALL be refused until a new start_i.

Configuration
REQ-035 With macro REG_FILE_LOADER_STATUS_EN defined, the module SHALL add output loaded_cnt_o (32 bits), which counts completed WRITE cycles since reset and saturates at all-ones.
REQ-036 Without REG_FILE_LOADER_STATUS_EN, the loaded_cnt_o port and its counter SHALL be absent, with all other behaviour unchanged.

Structure
REQ-037 The FSM state enum (loader_state_t) SHALL live in the shared hypercorex package.
REQ-038 The default BusWidth constant SHALL also live in the shared hypercorex package.
REQ-039 The module SHALL be flat, with no sub-modules; it drives the 1-write port of the existing register file directly.

Verification (all with DataWidth=64, BusWidth=32, NumRegs=4)
REQ-040 Start at addr 1, num 1, beats 0xAAAA0001 then 0xBBBB0002 -> one wr_en_o at addr 1 with data 0xBBBB0002AAAA0001; done_o pulses 1 cycle after the write.
REQ-041 Start at addr 3, num 3, six beats -> writes to addr 3, 0, 1 in order; busy_o stays high throughout.
REQ-042 Start with num 0 -> no write; done_o pulses 1 cycle after start; busy_o is high for 1 cycle.
REQ-043 Drop bus_valid_i for 5 cycles between beats, and pulse start_i mid-load -> data unchanged; the extra start is ignored.
REQ-044 Assert rst_i after 1 beat, then start at addr 2, num 1 with 2 beats -> no write before the restart; the write goes to addr 2 with only the new beats.
REQ-045 With REG_FILE_LOADER_STATUS_EN, run the REQ-041 scenario -> loaded_cnt_o equals 3.
